// File: rtl/fir_mon_pkg.sv
// Shared types, marker codes and arithmetic helpers for the FIR checkpoint monitor.
package fir_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEQ    = 3'd1,
    ST_ARMED  = 3'd2,
    ST_TIMING = 3'd3,
    ST_DONE   = 3'd4
  } mon_state_t;

  localparam logic [15:0] DEF_START_CODE = 16'h00A5;
  localparam logic [7:0]  DEF_END_CODE   = 8'h5A;
  localparam logic [15:0] PHASE_DD       = 16'h00DD;
  localparam logic [15:0] PHASE_CC       = 16'h00CC;

  localparam int unsigned SAT_W = 64;

  // Unsigned add clamped to the all-ones value of a w-bit result (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int unsigned      w);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
    return (sum > {1'b0, lim}) ? lim : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/fir_mon_seqmem.sv
// Expected-sequence register file: one synchronous write port, one asynchronous read port.
module fir_mon_seqmem #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SEQ_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(SEQ_DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [$clog2(SEQ_DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]            rdata
);

  logic [DATA_W-1:0] mem [SEQ_DEPTH];

  // Contents deliberately survive reset and soft clear.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_checkpoint_monitor.sv
// Watches the firmware status word, checks an expected value sequence, then times
// a fixed number of FIR runs delimited by start/end marker codes.
module fir_checkpoint_monitor
  import fir_mon_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned NUM_RUNS    = 3,
  parameter int unsigned SEQ_DEPTH   = 16,
  parameter logic [15:0] START_CODE  = DEF_START_CODE,
  parameter logic [7:0]  END_CODE    = DEF_END_CODE,
  parameter int unsigned TIMEOUT_CYC = 250000
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  input  logic [DATA_W-1:0]            chk_i,
  input  logic                         clr_i,
  input  logic                         exp_we_i,
  input  logic [$clog2(SEQ_DEPTH)-1:0] exp_addr_i,
  input  logic [DATA_W-1:0]            exp_data_i,
  input  logic [$clog2(SEQ_DEPTH):0]   exp_len_i,
  input  logic                         strict_i,
  output logic                         busy_o,
  output logic                         seq_pass_o,
  output logic                         seq_fail_o,
  output logic                         run_done_o,
  output logic [3:0]                   run_idx_o,
  output logic [CNT_W-1:0]             run_lat_o,
  output logic [7:0]                   run_y_o,
  output logic [CNT_W-1:0]             total_o,
  output logic                         timeout_o,
  output logic                         all_done_o
);

  localparam int unsigned AW = $clog2(SEQ_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic              soft_rst;
  logic [DATA_W-1:0] s_q, s_p, exp_word;
  logic              s_loaded_q, s_valid_q;
  mon_state_t        state_q, state_d;
  logic [LW-1:0]     idx_q;
  logic [CNT_W-1:0]  lat_q, elapsed_c;
  logic [3:0]        run_q;

  logic new_c, start_c, seq_hit_c, seq_done_c, seq_bad_c, end_c, timeout_c, last_run_c;
  logic idx_inc_c, pass_set_c, fail_set_c, lat_clr_c, lat_inc_c, run_end_c, run_to_c;

  assign soft_rst = wb_rst_i | clr_i;

  fir_mon_seqmem #(
    .DATA_W    (DATA_W),
    .SEQ_DEPTH (SEQ_DEPTH)
  ) u_seqmem (
    .clk   (wb_clk_i),
    .we    (exp_we_i),
    .waddr (exp_addr_i),
    .wdata (exp_data_i),
    .raddr (idx_q[AW-1:0]),
    .rdata (exp_word)
  );

  // Reported latency includes the edge that moved ARMED into TIMING.
  assign elapsed_c  = lat_q + CNT_W'(1);
  assign new_c      = s_valid_q && (s_q != s_p);
  assign start_c    = (s_q == DATA_W'(START_CODE));
  assign seq_hit_c  = new_c && (s_q == exp_word);
  assign seq_done_c = (idx_q >= exp_len_i) || (seq_hit_c && ((idx_q + LW'(1)) == exp_len_i));
  assign seq_bad_c  = new_c && !seq_hit_c && strict_i;
  assign end_c      = (s_q[7:0] == END_CODE);
  assign timeout_c  = !end_c && (elapsed_c >= CNT_W'(TIMEOUT_CYC));
  assign last_run_c = ((run_q + 4'd1) == 4'(NUM_RUNS));

  always_ff @(posedge wb_clk_i) begin
    if (soft_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   state_d = (exp_len_i == '0) ? ST_ARMED : ST_SEQ;
      ST_SEQ:    if (seq_done_c || seq_bad_c) state_d = ST_ARMED;
      ST_ARMED:  if (start_c) state_d = ST_TIMING;
      ST_TIMING: if (end_c || timeout_c) state_d = last_run_c ? ST_DONE : ST_ARMED;
      ST_DONE:   state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Per-state datapath strobes; an end match takes precedence over the timeout.
  always_comb begin
    idx_inc_c  = 1'b0;
    pass_set_c = 1'b0;
    fail_set_c = 1'b0;
    lat_clr_c  = 1'b0;
    lat_inc_c  = 1'b0;
    run_end_c  = 1'b0;
    run_to_c   = 1'b0;
    unique case (state_q)
      ST_IDLE:   pass_set_c = (exp_len_i == '0);
      ST_SEQ: begin
        idx_inc_c  = seq_hit_c;
        pass_set_c = seq_done_c;
        fail_set_c = seq_bad_c && !seq_done_c;
      end
      ST_ARMED:  lat_clr_c = start_c;
      ST_TIMING: begin
        run_end_c = end_c;
        run_to_c  = timeout_c;
        lat_inc_c = !end_c && !timeout_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (soft_rst) begin
      s_q        <= '0;
      s_p        <= '0;
      s_loaded_q <= 1'b0;
      s_valid_q  <= 1'b0;
      idx_q      <= '0;
      lat_q      <= '0;
      run_q      <= '0;
      busy_o     <= 1'b0;
      seq_pass_o <= 1'b0;
      seq_fail_o <= 1'b0;
      run_done_o <= 1'b0;
      run_idx_o  <= '0;
      run_lat_o  <= '0;
      run_y_o    <= '0;
      total_o    <= '0;
      timeout_o  <= 1'b0;
      all_done_o <= 1'b0;
    end else begin
      s_q        <= chk_i;
      s_p        <= s_q;
      s_loaded_q <= 1'b1;
      s_valid_q  <= s_loaded_q;
      if (idx_inc_c) idx_q <= idx_q + LW'(1);
      if (lat_clr_c)      lat_q <= '0;
      else if (lat_inc_c) lat_q <= elapsed_c;
      if (pass_set_c) seq_pass_o <= 1'b1;
      if (fail_set_c) seq_fail_o <= 1'b1;
      if (run_to_c)   timeout_o  <= 1'b1;
      run_done_o <= run_end_c;
      if (run_end_c) begin
        run_lat_o <= elapsed_c;
        run_y_o   <= s_q[15:8];
        run_idx_o <= run_q;
        total_o   <= CNT_W'(sat_add(SAT_W'(total_o), SAT_W'(elapsed_c), CNT_W));
      end
      if (run_end_c || run_to_c) run_q <= run_q + 4'd1;
      busy_o     <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      all_done_o <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_fir_checkpoint_monitor.sv
// Scoreboard bench for fir_checkpoint_monitor: sequence check, timed runs, timeout, reset abort.
module tb_fir_checkpoint_monitor;
  import fir_mon_pkg::*;

  localparam int unsigned TO = 350;
  localparam logic [15:0] SEQ_V [11] = '{16'h0000, 16'hFFF6, 16'hFFF7, 16'h0017, 16'h0038,
                                         16'h003F, 16'h0038, 16'h0017, 16'hFFF7, 16'hFFF6,
                                         16'h0000};

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [15:0] chk_i = PHASE_DD;
  logic        clr_i = 1'b0;
  logic        exp_we_i = 1'b0;
  logic [3:0]  exp_addr_i = '0;
  logic [15:0] exp_data_i = '0;
  logic [4:0]  exp_len_i = 5'd11;
  logic        strict_i = 1'b0;
  logic        busy_o, seq_pass_o, seq_fail_o, run_done_o, timeout_o, all_done_o;
  logic [3:0]  run_idx_o;
  logic [31:0] run_lat_o, total_o;
  logic [7:0]  run_y_o;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] lat;
    logic [7:0]  y;
  } run_exp_t;

  run_exp_t sb_q[$];
  int total_cnt = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  fir_checkpoint_monitor #(
    .DATA_W(16), .CNT_W(32), .NUM_RUNS(3), .SEQ_DEPTH(16),
    .START_CODE(16'h00A5), .END_CODE(8'h5A), .TIMEOUT_CYC(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .chk_i(chk_i), .clr_i(clr_i),
    .exp_we_i(exp_we_i), .exp_addr_i(exp_addr_i), .exp_data_i(exp_data_i),
    .exp_len_i(exp_len_i), .strict_i(strict_i), .busy_o(busy_o),
    .seq_pass_o(seq_pass_o), .seq_fail_o(seq_fail_o), .run_done_o(run_done_o),
    .run_idx_o(run_idx_o), .run_lat_o(run_lat_o), .run_y_o(run_y_o),
    .total_o(total_o), .timeout_o(timeout_o), .all_done_o(all_done_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [15:0] v, input int n);
    chk_i = v;
    tick(n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},     32'(busy_o),     32'd0);
    check({tag, "_pass"},     32'(seq_pass_o), 32'd0);
    check({tag, "_fail"},     32'(seq_fail_o), 32'd0);
    check({tag, "_run_done"}, 32'(run_done_o), 32'd0);
    check({tag, "_run_idx"},  32'(run_idx_o),  32'd0);
    check({tag, "_run_lat"},  run_lat_o,       32'd0);
    check({tag, "_run_y"},    32'(run_y_o),    32'd0);
    check({tag, "_total"},    total_o,         32'd0);
    check({tag, "_timeout"},  32'(timeout_o),  32'd0);
    check({tag, "_all_done"}, 32'(all_done_o), 32'd0);
  endtask

  task automatic release_reset();
    wb_rst_i = 1'b0;
    clr_i    = 1'b0;
    tick(3);
  endtask

  task automatic seq_with_markers();
    for (int i = 0; i < 11; i++) begin
      drive_word(SEQ_V[i], 3);
      drive_word((i % 2 == 1) ? PHASE_CC : PHASE_DD, 3);
    end
  endtask

  // Issue one run; the expected completion record goes to the scoreboard.
  task automatic do_run(input int n, input logic [7:0] y, input logic [3:0] idx);
    run_exp_t e;
    drive_word(16'h00A5, n);
    e.idx = idx;
    e.lat = 32'(n);
    e.y   = y;
    sb_q.push_back(e);
    drive_word({y, 8'h5A}, 5);
  endtask

  always @(negedge clk) begin : monitor
    run_exp_t e;
    if (run_done_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        bad_cnt++;
        $display("FAIL unexpected_run_done: got pulse idx=%0d lat=%0d want no pulse", run_idx_o, run_lat_o);
      end else begin
        e = sb_q.pop_front();
        check("run_idx", 32'(run_idx_o), 32'(e.idx));
        check("run_lat", run_lat_o, e.lat);
        check("run_y",   32'(run_y_o), 32'(e.y));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Phase A: load expected memory under reset, lenient sequence with markers, three runs
    for (int i = 0; i < 11; i++) begin
      exp_we_i   = 1'b1;
      exp_addr_i = 4'(i);
      exp_data_i = SEQ_V[i];
      tick(1);
    end
    exp_we_i = 1'b0;
    check_zero("reset");
    release_reset();
    check("seq_busy", 32'(busy_o), 32'd1);
    seq_with_markers();
    check("a_pass",  32'(seq_pass_o), 32'd1);
    check("a_fail",  32'(seq_fail_o), 32'd0);
    check("a_armed", 32'(busy_o),     32'd1);
    do_run(100, 8'h2D, 4'd0);
    check("a_total1", total_o, 32'd100);
    do_run(200, 8'h11, 4'd1);
    do_run(300, 8'h33, 4'd2);
    check("a_total",    total_o,         32'd600);
    check("a_all_done", 32'(all_done_o), 32'd1);
    check("a_run_idx",  32'(run_idx_o),  32'd2);
    check("a_busy",     32'(busy_o),     32'd0);
    drive_word(16'h00A5, 20);
    drive_word(16'h445A, 10);
    check("a_4th_total", total_o,   32'd600);
    check("a_4th_lat",   run_lat_o, 32'd300);
    check("a_sb_drained", 32'(sb_q.size()), 32'd0);

    // Phase B: strict mode, 24 in place of the first 23
    chk_i    = PHASE_DD;
    strict_i = 1'b1;
    wb_rst_i = 1'b1;
    tick(2);
    release_reset();
    for (int i = 0; i < 3; i++) drive_word(SEQ_V[i], 3);
    check("b_fail_before", 32'(seq_fail_o), 32'd0);
    drive_word(16'h0018, 3);
    check("b_fail",  32'(seq_fail_o), 32'd1);
    check("b_pass",  32'(seq_pass_o), 32'd0);
    check("b_armed", 32'(busy_o),     32'd1);

    // Phase C: lenient mode via soft clear, the 24 is skipped and a later 23 completes
    chk_i    = PHASE_DD;
    strict_i = 1'b0;
    clr_i    = 1'b1;
    tick(2);
    release_reset();
    for (int i = 0; i < 11; i++) begin
      if (i == 3) begin
        drive_word(16'h0018, 3);
        check("c_pass_after_24", 32'(seq_pass_o), 32'd0);
      end
      drive_word(SEQ_V[i], 3);
    end
    check("c_pass", 32'(seq_pass_o), 32'd1);
    check("c_fail", 32'(seq_fail_o), 32'd0);

    // Phase D: empty sequence, timeout run, then a run ending exactly at the limit
    chk_i     = 16'h0001;
    exp_len_i = 5'd0;
    wb_rst_i  = 1'b1;
    tick(2);
    release_reset();
    check("d_pass_len0", 32'(seq_pass_o), 32'd1);
    check("d_armed",     32'(busy_o),     32'd1);
    drive_word(16'h00A5, 5);
    drive_word(16'h0001, TO - 10);
    check("d_timeout_early", 32'(timeout_o), 32'd0);
    tick(20);
    check("d_timeout",       32'(timeout_o), 32'd1);
    check("d_total_to",      total_o,        32'd0);
    do_run(TO, 8'h2D, 4'd1);
    check("d_total_edge",   total_o,        32'd350);
    check("d_timeout_held", 32'(timeout_o), 32'd1);

    // Phase E: reset mid-run, then the retained memory still drives a passing check
    exp_len_i = 5'd11;
    drive_word(16'h00A5, 42);
    wb_rst_i = 1'b1;
    tick(1);
    check_zero("abort");
    chk_i = PHASE_DD;
    tick(1);
    release_reset();
    seq_with_markers();
    check("e_pass", 32'(seq_pass_o), 32'd1);
    check("e_fail", 32'(seq_fail_o), 32'd0);
    tick(5);
    check("sb_left", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
